// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU controller: op codes, ALUOp classes, funct7 values,
// the RV32M funct3 set and the multiply/divide sequencer states.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  localparam logic [1:0] ALUOP_LW_SW = 2'd0;
  localparam logic [1:0] ALUOP_B_T   = 2'd1;
  localparam logic [1:0] ALUOP_R_T   = 2'd2;
  localparam logic [1:0] ALUOP_I_T   = 2'd3;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_e;

  // Op code for the funct3 values whose meaning does not depend on funct7.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_signed_div(input md_op_e op);
    return op inside {MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/md_iter_datapath.sv
// Iterative multiply/divide datapath: unsigned shift-add or restoring-divide step on
// operand magnitudes, one step per enable, with sign correction in the fix cycle.
module md_iter_datapath
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            special_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  md_op_e          op_q;
  logic            neg_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] result_q;

  logic            a_neg, b_neg, neg_d;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_r, div_t;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fix_val, special_val;

  always_comb begin
    a_neg = a_i[XLEN-1] & (op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    b_neg = b_i[XLEN-1] & (op_i inside {MD_MULH, MD_DIV, MD_REM});
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
    // The remainder takes the dividend's sign; everything else the product of signs.
    neg_d = (op_i == MD_REM) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
    div_r   = {hi_q, lo_q[XLEN-1]};
    div_t   = div_r - {1'b0, mcand_q};
  end

  always_comb begin
    prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s  = neg_q ? -lo_q : lo_q;
    rem_s  = neg_q ? -hi_q : hi_q;
    case (op_q)
      MD_MUL:                     fix_val = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            fix_val = quo_s;
      default:                    fix_val = rem_s;
    endcase
  end

  always_comb begin
    if (b_i == '0) special_val = (op_i inside {MD_DIV, MD_DIVU}) ? '1 : a_i;
    else           special_val = (op_i == MD_DIV) ? a_i : '0;
  end

  // NOTE: working registers carry no reset; they are always loaded at start before use.
  always_ff @(posedge clk) begin
    if (start_i) begin
      op_q    <= op_i;
      neg_q   <= neg_d;
      mcand_q <= b_mag;
      hi_q    <= '0;
      lo_q    <= a_mag;
    end else if (step_i) begin
      if (md_is_div(op_q)) begin
        hi_q <= div_t[XLEN] ? div_r[XLEN-1:0] : div_t[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], ~div_t[XLEN]};
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            result_q <= '0;
    else if (special_i) result_q <= special_val;
    else if (fix_i)     result_q <= fix_val;
  end

  assign result_o = result_q;

endmodule

// File: rtl/alu_md_controller.sv
// ALU control decoder plus an iterative RV32M sequencer with a busy/done stall handshake.
// Decode outputs are combinational and independent of the sequencer state.
module alu_md_controller
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [OP_W-1:0] ALUOperation,
  output logic            signSel,
  output logic            illegal,
  output logic            mdBusy,
  output logic            mdDone,
  output logic [XLEN-1:0] mdResult
);

  logic [3:0] op_code;
  logic       matched, md_req;

  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    op_code = OP_ADD;
    matched = 1'b0;
    md_req  = 1'b0;
    case (ALUOp)
      ALUOP_LW_SW: matched = 1'b1;
      ALUOP_B_T: begin
        op_code = OP_SUB;
        matched = 1'b1;
      end
      ALUOP_R_T: begin
        if (func7 == F7_BASE) begin
          op_code = base_op(func3);
          matched = 1'b1;
        end else if (func7 == F7_ALT) begin
          if (func3 == 3'b000) begin
            op_code = OP_SUB;
            matched = 1'b1;
          end else if (func3 == 3'b101) begin
            op_code = OP_SRA;
            matched = 1'b1;
          end
        end else if (func7 == F7_MULDIV) begin
          md_req = 1'b1;
        end
      end
      default: begin
        // I-type: funct7 bits are immediate except for the shift encodings.
        case (func3)
          3'b001: begin
            if (func7 == F7_BASE) begin
              op_code = OP_SLL;
              matched = 1'b1;
            end
          end
          3'b101: begin
            if (func7 == F7_BASE) begin
              op_code = OP_SRL;
              matched = 1'b1;
            end else if (func7 == F7_ALT) begin
              op_code = OP_SRA;
              matched = 1'b1;
            end
          end
          default: begin
            op_code = base_op(func3);
            matched = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign ALUOperation = OP_W'(op_code);
  assign signSel      = (op_code == OP_SLTU);
  assign illegal      = valid & ~matched & ~md_req;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           req_op;
  logic             md_fire, special;
  logic             dp_start, dp_special, dp_step, dp_fix;

  always_comb begin
    req_op  = md_op_e'(func3);
    md_fire = valid & md_req;
    special = md_is_div(req_op) &
              ((b == '0) |
               (md_is_signed_div(req_op) & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1)));
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (md_fire) begin
          cnt_d = CNT_W'(XLEN);
          if (special)                state_d = ST_DONE;
          else if (md_is_div(req_op)) state_d = ST_DIV;
          else                        state_d = ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mdBusy     = 1'b0;
    mdDone     = 1'b0;
    dp_start   = 1'b0;
    dp_special = 1'b0;
    dp_step    = 1'b0;
    dp_fix     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mdBusy     = md_fire;
        dp_start   = md_fire & ~special;
        dp_special = md_fire & special;
      end
      ST_MUL, ST_DIV: begin
        mdBusy  = 1'b1;
        dp_step = 1'b1;
      end
      ST_FIX: begin
        mdBusy = 1'b1;
        dp_fix = 1'b1;
      end
      default: mdDone = 1'b1;
    endcase
  end

  md_iter_datapath #(.XLEN(XLEN)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .start_i  (dp_start),
    .special_i(dp_special),
    .step_i   (dp_step),
    .fix_i    (dp_fix),
    .op_i     (req_op),
    .a_i      (a),
    .b_i      (b),
    .result_o (mdResult)
  );

endmodule

// File: doc/alu_md_controller.md
# alu_md_controller

Parametrised successor to the single-cycle ALU controller. Decodes `ALUOp`/`func3`/`func7` into a widened ALU operation code and flags undecodable encodings as illegal instead of driving high-Z. Adds an iterative RV32M multiply/divide sequencer with a busy/done stall handshake to the pipeline. Sits between the decode stage and the EX-stage ALU; `mdResult` is muxed into the EX result by the datapath.

## Interface
- `XLEN`, 32: operand/result width; even, ≥8.
- `OP_W`, 4: width of `ALUOperation`.
- `CNT_W`, $clog2(XLEN+1): iteration counter width.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `valid`  in  1  decode-stage instruction valid
- `ALUOp`  in  2  0 lw_sw, 1 B_T, 2 R_T, 3 I_T
- `func3`  in  3  instruction funct3
- `func7`  in  7  instruction funct7
- `a`, `b`  in  XLEN  rs1/rs2 operands, sampled at M-op start
- `ALUOperation`  out  OP_W  ALU op code (combinational)
- `signSel`  out  1  1 when `ALUOperation`==SLTU
- `illegal`  out  1  `valid` and encoding unmatched (combinational)
- `mdBusy`  out  1  stall request to pipeline
- `mdDone`  out  1  one-cycle pulse: `mdResult` valid
- `mdResult`  out  XLEN  M-op result, held until next start

## Operation
- Op codes: ADD 0, SUB 1, AND 2, OR 3, SLT 4, SLTU 5, XOR 6, SLL 7, SRL 8, SRA 9.
- lw_sw→ADD; B_T→SUB.
- R_T, func7 0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- R_T, func7 0100000: f3 000 SUB, 101 SRA.
- I_T: f3 000 ADD, 001 SLL (func7 0), 010 SLT, 011 SLTU, 100 XOR, 101 SRL (func7 0) / SRA (func7 0100000), 110 OR, 111 AND.
- Any other combination: `ALUOperation`=ADD, `illegal`=`valid`.
- R_T with func7 0000001 is an M-op (`mdReq`): f3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. `ALUOperation`=ADD, `illegal`=0.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE: if `valid & mdReq`, latch the op, take the magnitude of signed operands (record result sign), load counter=XLEN, go to MUL or DIV.
  - MUL/DIV: one shift-add (2·XLEN-bit product) or restoring-subtract step per cycle; counter decrements; at 1 go to FIX.
  - FIX: apply sign, select low/high half, quotient or remainder; go to DONE.
  - DONE: `mdDone`=1; go to IDLE.
- Special cases are detected in IDLE and go directly to DONE with the result preloaded:
  - Divide by zero: DIV/DIVU→all ones; REM/REMU→`a`.
  - Signed overflow (`a`=−2^(XLEN−1), `b`=−1): DIV→`a`; REM→0.
- `mdBusy` = (state ∉ {IDLE, DONE}) | (state==IDLE & `valid` & `mdReq`). `mdBusy` is 0 in DONE, so the pipeline advances that cycle. Because state≠IDLE in DONE, a still-asserted request does not restart.
- The decode outputs are purely combinational and independent of the FSM.

## Timing
- Start accepted at cycle 0 (IDLE).
- Normal M-op: MUL/DIV occupies cycles 1..XLEN, FIX is cycle XLEN+1, `mdDone` is high in cycle XLEN+2 (XLEN=32: cycle 34).
- Special case: `mdDone` is high in cycle 1.
- Back-to-back M-ops: the next start is accepted no earlier than the cycle after DONE.
- Reset values: state IDLE, counter 0, `mdResult` 0, `mdDone` 0, registered part of `mdBusy` 0.
- `rst` mid-operation aborts at the next edge with no `mdDone`.
- `a`, `b` and the op are sampled only at start; later input changes are ignored.

## Structure
- Package `alu_ctrl_pkg`: ALU op-code localparams, ALUOp encodings, funct7 constants (0000000, 0100000, 0000001), M-op funct3 enum, FSM state enum.
- Sub-module `md_iter_datapath`: accumulator/quotient/remainder registers, one iteration per enable, sign-fix logic. The top level holds the decoder and the FSM.

## Test plan
- Decode sweep: all ALUOp/func3/func7 legal combinations → expected code.
  - R_T f3 011 func7 0 → SLTU and `signSel`=1.
  - R_T f3 000 func7 0100001 → ADD and `illegal`=1.
- MUL: `a`=7, `b`=−3 → `mdResult`=0xFFFF_FFEB. `mdBusy` high cycles 0..33; `mdDone` pulse at cycle 34.
- MULHU: `a`=`b`=0xFFFF_FFFF → 0xFFFF_FFFE. MULH: `a`=−1, `b`=−1 → 0.
- DIV: `a`=−20, `b`=3 → −6. REM → −2. DIVU: `a`=20, `b`=3 → 6.
- Special cases:
  - DIV `b`=0 → 0xFFFF_FFFF, `mdDone` at cycle 1.
  - REMU `b`=0 → `a`.
  - DIV 0x8000_0000 / −1 → 0x8000_0000.
- `rst` asserted at cycle 10 of a DIV → state IDLE next cycle, no `mdDone`, `mdResult`=0. A new MUL then completes normally.
